// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and sizes for the stack controller and the stack
// Purpose: op and FSM state encodings, data width and stack depth shared by
//          stack_ctrl, stack_ctrl_if and stack.
package stack_pkg;

  localparam int W         = 2;
  localparam int STK_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_DRAIN = 2'b10,
    OP_PEEK  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - host command/response handshake bundle for stack_ctrl
// Purpose: groups the host-side request and response channels.
// Signals:
//   cmd_valid/cmd_ready  request handshake, cmd_op/cmd_data request fields
//   rsp_valid/rsp_ready  response handshake, rsp_data/rsp_err/rsp_last fields
// Modports: master = host side, slave = stack_ctrl side.
interface stack_ctrl_if;
  import stack_pkg::*;

  logic         cmd_valid;
  logic         cmd_ready;
  op_e          cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last
  );

endinterface

// File: rtl/stack.sv
// rtl/stack.sv - simple LIFO with single-cycle push/pop strobes
// Purpose: storage that stack_ctrl drives; instantiated beside stack_ctrl.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears count only)
//   push, pop       one-cycle strobes; push wins if both are ever high
//   data_in         value written on push
//   data_out        current top, combinational; 0 while empty
//   full, empty     occupancy flags
module stack
  import stack_pkg::*;
#(
  parameter int DEPTH = STK_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] top_idx;

  assign top_idx  = AW'(cnt - CW'(1));
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign data_out = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[cnt[AW-1:0]] <= data_in;
      cnt              <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - host-side command initiator for the LIFO stack
// Purpose: accepts push/pop/peek/drain requests, strobes the stack, and returns
//          one response per command (or a beat stream ending in a terminator
//          for drain). Rejected ops are counted in a saturating counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   host          stack_ctrl_if.slave: command and response handshakes
//   stk_push/pop  one-cycle strobes to the stack, only ever in EXEC
//   stk_wdata     push data (0 when not pushing)
//   stk_rdata     stack top, combinational
//   stk_full/empty stack flags, sampled in EXEC
//   err_cnt       saturating count of rejected ops
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  stack_ctrl_if.slave      host,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [W-1:0]     stk_wdata,
  input  logic [W-1:0]     stk_rdata,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [CNT_W-1:0] err_cnt
);

  state_e       state;
  op_e          op_q;
  logic [W-1:0] data_q;
  logic         in_exec;
  logic         exec_err;
  logic         drain_beat;
  logic         capture;

  // Strobes depend on the flags seen in the EXEC cycle itself, so they are
  // decoded from the registered state; rst masks any strobe in a reset cycle.
  assign in_exec    = (state == ST_EXEC) && !rst;
  assign stk_push   = in_exec && (op_q == OP_PUSH) && !stk_full;
  assign stk_pop    = in_exec && ((op_q == OP_POP) || (op_q == OP_DRAIN)) && !stk_empty;
  assign stk_wdata  = stk_push ? data_q : '0;

  assign exec_err   = ((op_q == OP_PUSH) && stk_full) ||
                      (((op_q == OP_POP) || (op_q == OP_PEEK)) && stk_empty);
  assign drain_beat = (op_q == OP_DRAIN) && !stk_empty;
  assign capture    = (op_q != OP_PUSH) && !stk_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      op_q           <= OP_PUSH;
      data_q         <= '0;
      host.cmd_ready <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      host.rsp_err   <= 1'b0;
      host.rsp_last  <= 1'b0;
      err_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host.cmd_valid && host.cmd_ready) begin
            op_q           <= host.cmd_op;
            data_q         <= host.cmd_data;
            host.cmd_ready <= 1'b0;
            state          <= ST_EXEC;
          end else begin
            host.cmd_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          host.rsp_valid <= 1'b1;
          host.rsp_err   <= exec_err;
          host.rsp_last  <= !drain_beat;
          host.rsp_data  <= capture ? stk_rdata : '0;
          if (exec_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (host.rsp_ready) begin
            host.rsp_valid <= 1'b0;
            // A drain data beat loops back for the next item; the stack has
            // already updated by the time EXEC samples it again.
            if (!host.rsp_last) begin
              state <= ST_EXEC;
            end else begin
              state          <= ST_IDLE;
              host.cmd_ready <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - scoreboard bench for stack_ctrl driving a stack instance
module tb_stack_ctrl;
  import stack_pkg::*;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
    logic         last;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stk_rst = 1'b1;
  logic         stk_push, stk_pop, stk_full, stk_empty;
  logic [W-1:0] stk_wdata, stk_rdata;
  logic [7:0]   err_cnt;

  stack_ctrl_if bus ();

  stack_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (bus.slave),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .err_cnt   (err_cnt)
  );

  stack #(.DEPTH(STK_DEPTH)) u_stk (
    .clk      (clk),
    .rst      (stk_rst),
    .push     (stk_push),
    .pop      (stk_pop),
    .data_in  (stk_wdata),
    .data_out (stk_rdata),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_push = 0, n_pop = 0, exp_push = 0, exp_pop = 0, exp_err = 0;
  int last_acc = 0;
  int model[$];
  logic [W-1:0] wq[$];
  rsp_t sb[$];
  rsp_t held, exp_r;
  logic held_v = 1'b0;
  logic tog_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t mk(input int d, input bit e, input bit l);
    rsp_t r;
    r.data = d[W-1:0];
    r.err  = e;
    r.last = l;
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      bus.rsp_ready = ~bus.rsp_ready;
    end
  end

  // Strobe and response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (stk_push || stk_pop) chk("strobe_excl", {31'd0, stk_push & stk_pop}, 0);
    if (stk_push) begin
      n_push++;
      chk("push_when_full", {31'd0, stk_full}, 0);
      if (wq.size() == 0) chk("push_unexpected", {31'd0, stk_push}, 0);
      else chk("wdata", {30'd0, stk_wdata}, {30'd0, wq.pop_front()});
    end
    if (stk_pop) begin
      n_pop++;
      chk("pop_when_empty", {31'd0, stk_empty}, 0);
    end
    if (held_v && bus.rsp_valid)
      chk("rsp_stable", {28'd0, bus.rsp_data, bus.rsp_err, bus.rsp_last}, {28'd0, held});
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", {31'd0, bus.rsp_valid}, 0);
      else begin
        exp_r = sb.pop_front();
        chk("rsp", {28'd0, bus.rsp_data, bus.rsp_err, bus.rsp_last}, {28'd0, exp_r});
      end
    end
    held_v = bus.rsp_valid && !bus.rsp_ready;
    held   = {bus.rsp_data, bus.rsp_err, bus.rsp_last};
  end

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic expect_op(input op_e op, input logic [W-1:0] d);
    int v;
    case (op)
      OP_PUSH: begin
        if (model.size() == STK_DEPTH) begin
          sb.push_back(mk(0, 1, 1));
          bump_err();
        end else begin
          model.push_back(int'(d));
          wq.push_back(d);
          exp_push++;
          sb.push_back(mk(0, 0, 1));
        end
      end
      OP_POP: begin
        if (model.size() == 0) begin
          sb.push_back(mk(0, 1, 1));
          bump_err();
        end else begin
          v = model.pop_back();
          exp_pop++;
          sb.push_back(mk(v, 0, 1));
        end
      end
      OP_PEEK: begin
        if (model.size() == 0) begin
          sb.push_back(mk(0, 1, 1));
          bump_err();
        end else begin
          sb.push_back(mk(model[$], 0, 1));
        end
      end
      default: begin
        while (model.size() > 0) begin
          v = model.pop_back();
          exp_pop++;
          sb.push_back(mk(v, 0, 0));
        end
        sb.push_back(mk(0, 0, 1));
      end
    endcase
  endtask

  // Called right after a rising edge; leaves cmd_valid high for chaining.
  task automatic issue(input op_e op, input logic [W-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    expect_op(op, d);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    if (!bus.cmd_ready) chk("cmd_ready_timeout", {31'd0, bus.cmd_ready}, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.cmd_ready && sb.size() == 0) break;
    end
    if (!(bus.cmd_ready && sb.size() == 0)) chk("idle_timeout", sb.size(), 0);
    tog_en = 1'b0;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_strobes", {30'd0, stk_push, stk_pop}, 0);
    @(posedge clk); #1;
    rst = 1'b0; stk_rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_pre", {31'd0, bus.cmd_ready}, 0);
    @(posedge clk); #1;
    chk("cmd_ready_post", {31'd0, bus.cmd_ready}, 1);

    // Back-to-back pushes.
    issue(OP_PUSH, 2'd1); a0 = last_acc;
    issue(OP_PUSH, 2'd2); a1 = last_acc;
    issue(OP_PUSH, 2'd3); a2 = last_acc;
    idle();
    chk("spacing01", a1 - a0, 3);
    chk("spacing12", a2 - a1, 3);
    chk("n_push_3", n_push, 3);

    // Pop, then two peeks with no strobe.
    issue(OP_POP, 0);
    idle();
    issue(OP_PEEK, 0);
    issue(OP_PEEK, 0);
    idle();
    chk("n_pop_1", n_pop, 1);

    // Drain {1,2,3} under toggling backpressure.
    issue(OP_PUSH, 2'd3);
    idle();
    tog_en = 1'b1;
    issue(OP_DRAIN, 0);
    idle();
    chk("drain_empty", {31'd0, stk_empty}, 1);
    chk("n_pop_drain", n_pop, exp_pop);

    // Drain of an empty stack, then rejected pop.
    issue(OP_DRAIN, 0);
    idle();
    issue(OP_POP, 0);
    idle();
    chk("err_cnt_1", err_cnt, 1);
    chk("err_cnt_model1", err_cnt, exp_err);
    chk("n_pop_err", n_pop, exp_pop);

    // Fill, then push on full.
    issue(OP_PUSH, 2'd1);
    issue(OP_PUSH, 2'd2);
    issue(OP_PUSH, 2'd0);
    issue(OP_PUSH, 2'd3);
    issue(OP_PUSH, 2'd1);
    idle();
    chk("full_flag", {31'd0, stk_full}, 1);
    chk("n_push_full", n_push, exp_push);
    chk("err_cnt_2", err_cnt, 2);

    // Reset while a drain beat is stalled.
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_DRAIN;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    void'(model.pop_back());
    exp_pop++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    chk("stall_valid", {31'd0, bus.rsp_valid}, 1);
    chk("stall_data", {30'd0, bus.rsp_data}, 3);
    chk("stall_last", {31'd0, bus.rsp_last}, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_valid_held", {31'd0, bus.rsp_valid}, 1);
    chk("stall_no_extra_pop", n_pop, exp_pop);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 0;
    @(negedge clk);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_pops", n_pop, exp_pop);
    chk("mid_rst_pushes", n_push, exp_push);
    @(posedge clk); #1;
    chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 1);
    bus.rsp_ready = 1'b1;
    issue(OP_PUSH, 2'd2);
    idle();
    chk("n_push_after_rst", n_push, exp_push);

    // Empty the stack, then saturate the error counter.
    issue(OP_DRAIN, 0);
    idle();
    for (int i = 0; i < 300; i++) issue(OP_POP, 0);
    idle();
    chk("err_cnt_sat", err_cnt, 255);
    chk("err_cnt_model", err_cnt, exp_err);
    chk("n_pop_final", n_pop, exp_pop);
    chk("wq_drained", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
